// File: rtl/ac_motor_run_sequencer_if.sv
// Command/status bundle between the operator side and the run sequencer.
// The master drives commands; the slave returns the drive-chain outputs.
interface ac_motor_run_sequencer_if;
  logic        run;
  logic        dir_req;
  logic [11:0] power_target;
  logic        fault;
  logic        fault_clr;
  logic [11:0] power;
  logic        enable;
  logic        cw;
  logic        ccw;
  logic        at_target;
  logic        fault_latched;
  logic [2:0]  state;

  modport master (
    output run, dir_req, power_target, fault, fault_clr,
    input  power, enable, cw, ccw, at_target, fault_latched, state
  );

  modport slave (
    input  run, dir_req, power_target, fault, fault_clr,
    output power, enable, cw, ccw, at_target, fault_latched, state
  );
endinterface

// File: rtl/ac_motor_run_sequencer.sv
// Run sequencer for the AC motor drive chain: rate-limited power ramp,
// reversal via stop/dwell, and a latched shoot-through fault.
module ac_motor_run_sequencer #(
  parameter int RAMP_DIV     = 16,
  parameter int DWELL_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  ac_motor_run_sequencer_if.slave bus
);

  localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [PW-1:0] PMAX = PW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DMAX = DW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STOP  = 3'd2,
    DWELL = 3'd3,
    FAULT = 3'd4
  } state_t;

  state_t        st;
  logic [11:0]   pwr;
  logic          en;
  logic          cw_q;
  logic          ccw_q;
  logic          at_q;
  logic          flt_q;
  logic          dir_q;
  logic          arm;
  logic [PW-1:0] presc;
  logic [DW-1:0] dcnt;

  logic          tick;
  logic [11:0]   ramp;

  // Target bounds the step, so no wrap at either end
  always_comb begin
    tick = (presc == PMAX);
    ramp = pwr;
    if (tick) begin
      if (pwr < bus.power_target)
        ramp = pwr + 12'd1;
      else if (pwr > bus.power_target)
        ramp = pwr - 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      pwr   <= '0;
      en    <= 1'b0;
      cw_q  <= 1'b0;
      ccw_q <= 1'b0;
      at_q  <= 1'b0;
      flt_q <= 1'b0;
      dir_q <= 1'b0;
      arm   <= 1'b0;
      presc <= '0;
      dcnt  <= '0;
    end else begin
      if (!bus.run)
        arm <= 1'b1;
      if (bus.fault) begin
        st    <= FAULT;
        pwr   <= '0;
        en    <= 1'b0;
        cw_q  <= 1'b0;
        ccw_q <= 1'b0;
        at_q  <= 1'b0;
        flt_q <= 1'b1;
      end else begin
        unique case (st)
          IDLE: begin
            if (bus.run && arm) begin
              st    <= RUN;
              arm   <= 1'b0;
              dir_q <= bus.dir_req;
              en    <= 1'b1;
              cw_q  <= !bus.dir_req;
              ccw_q <= bus.dir_req;
              pwr   <= '0;
              presc <= '0;
              at_q  <= (bus.power_target == 12'd0);
            end
          end
          RUN: begin
            if (!bus.run || (bus.dir_req != dir_q)) begin
              st    <= STOP;
              presc <= '0;
              at_q  <= 1'b0;
            end else begin
              presc <= tick ? '0 : presc + 1'b1;
              pwr   <= ramp;
              at_q  <= (ramp == bus.power_target);
            end
          end
          STOP: begin
            if (pwr == 12'd0) begin
              st    <= DWELL;
              en    <= 1'b0;
              cw_q  <= 1'b0;
              ccw_q <= 1'b0;
              dcnt  <= '0;
            end else begin
              presc <= tick ? '0 : presc + 1'b1;
              if (tick)
                pwr <= pwr - 12'd1;
            end
          end
          DWELL: begin
            if (dcnt == DMAX) begin
              if (bus.run) begin
                st    <= RUN;
                dir_q <= bus.dir_req;
                en    <= 1'b1;
                cw_q  <= !bus.dir_req;
                ccw_q <= bus.dir_req;
                pwr   <= '0;
                presc <= '0;
                at_q  <= (bus.power_target == 12'd0);
              end else begin
                st <= IDLE;
              end
            end else begin
              dcnt <= dcnt + 1'b1;
            end
          end
          FAULT: begin
            if (bus.fault_clr) begin
              st    <= IDLE;
              flt_q <= 1'b0;
            end
          end
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign bus.power         = pwr;
  assign bus.enable        = en;
  assign bus.cw            = cw_q;
  assign bus.ccw           = ccw_q;
  assign bus.at_target     = at_q;
  assign bus.fault_latched = flt_q;
  assign bus.state         = st;

endmodule

// File: doc/ac_motor_run_sequencer.md
# ac_motor_run_sequencer

Sequencer in front of the AC motor drive chain (control → modulation → direction select → switch delay). It drives the chain's `power`, `enable`, `cw` and `ccw` inputs from operator-level commands. It ramps power at a controlled rate and handles direction reversal by ramping to zero, removing drive for a dead time, then restarting. It latches a shoot-through fault and drops drive within one clock.

## Interface

Parameters:
- `RAMP_DIV`, default 16: clocks per 1-LSB power step (≥1). Full 0→4095 ramp takes 4095·RAMP_DIV clocks.
- `DWELL_CYCLES`, default 4096: clocks with drive removed between stop and restart (≥1).

Ports. Clocking is fixed: a single clock, and reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  request to drive the motor.
- `dir_req`  in  1  requested direction: 0 = cw, 1 = ccw.
- `power_target`  in  12  requested power level; may change at any time.
- `fault`  in  1  shoot-through / short indication, sampled synchronously.
- `fault_clr`  in  1  clears a latched fault.
- `power`  out  12  ramped power to the drive chain.
- `enable`  out  1  switch-delay enable.
- `cw`  out  1  clockwise select.
- `ccw`  out  1  counter-clockwise select.
- `at_target`  out  1  high when state is RUN and `power == power_target`.
- `fault_latched`  out  1  high while in state FAULT.
- `state`  out  3  encoding: IDLE=0, RUN=1, STOP=2, DWELL=3, FAULT=4.

## Operation

- All outputs are registered.
- Reset value of every output is 0; `state` resets to IDLE. Internal registers also reset: `dir_q`=0, `arm`=0, prescaler=0, dwell counter=0.
- **Prescaler:**
  - Counts 0..RAMP_DIV−1 in RUN and STOP; it is cleared on entry to either state.
  - A "tick" is the cycle where prescaler == RAMP_DIV−1.
- **Arming:** `arm` is set whenever `run`=0 is sampled and cleared on leaving IDLE. It prevents a restart straight out of FAULT while `run` is held high.
- **IDLE:**
  - Outputs: `power`=0, `enable`=0, `cw`=`ccw`=0.
  - If `run`=1 and `arm`=1: latch `dir_q`←`dir_req` and go to RUN.
- **RUN:**
  - Outputs: `enable`=1, `cw`=!`dir_q`, `ccw`=`dir_q`.
  - On each tick: `power`+1 if `power` < `power_target`; `power`−1 if `power` > `power_target`; otherwise hold.
  - Exit to STOP if `run`=0 or `dir_req`≠`dir_q`.
- **STOP:**
  - `enable` and direction outputs are held as in RUN.
  - If `power`==0, go to DWELL; otherwise `power`−1 on each tick. `power_target` is ignored.
- **DWELL:**
  - Outputs: `enable`=0, `cw`=`ccw`=0, `power`=0.
  - The counter is cleared on entry. The block leaves at the edge where the counter == DWELL_CYCLES−1.
  - On exit: go to RUN (latching `dir_req`) if `run`=1, else IDLE.
- **FAULT:**
  - Entered from any state when `fault`=1 is sampled; this has the highest priority.
  - Outputs: `power`=0, `enable`=0, `cw`=`ccw`=0.
  - Exits to IDLE only when `fault_clr`=1 and `fault`=0 in the same cycle.
- **Arithmetic:**
  - 12-bit unsigned, no wrap: `power` never exceeds 4095 or goes below 0.
  - Prescaler width is clog2(RAMP_DIV); dwell counter width is clog2(DWELL_CYCLES).
- `cw` and `ccw` are never both 1.

## Timing

- IDLE→RUN: `run` sampled high at edge k → at edge k `state`=RUN, `enable`=1, direction valid, `power`=0. First increment lands at edge k+RAMP_DIV.
- Step rate: exactly one LSB per RAMP_DIV clocks in RUN and STOP.
- A target change mid-ramp reverses the step direction at the next tick; the prescaler is not reset.
- STOP with `power`=0 → DWELL at the next edge. `enable` stays 1 for that one cycle with `power`=0.
- DWELL lasts exactly DWELL_CYCLES clocks with `enable`=0.
- Fault response: `fault` high at edge k → `enable`/`power`/`cw`/`ccw` are 0 after edge k. There is no ramp-down.
- Simultaneous events:
  - `fault` beats everything.
  - In RUN, `run`=0 and a direction change together → STOP (single path).
  - `fault_clr` while `fault`=1 is ignored.
- Reset mid-operation: all outputs are 0 immediately (asynchronous); the next action is IDLE arming.

## Test plan

(Bench parameters: RAMP_DIV=4, DWELL_CYCLES=8.)

1. Start-up ramp:
   - Stimulus: reset, `run`=0 for 2 clk, then `run`=1, `dir_req`=0, `power_target`=10.
   - Response: RUN next edge, `cw`=1, `enable`=1; `power` reaches 10 after 40 clk; `at_target`=1 thereafter.
2. Target change:
   - Stimulus: during the ramp at `power`=5, set `power_target`=3.
   - Response: `power` steps 5→4→3, one step per 4 clk, then holds; `at_target`=1.
3. Reversal:
   - Stimulus: at `power`=10 in RUN, set `dir_req`=1.
   - Response: STOP; `power` reaches 0 after 40 clk; `enable` falls one clk later; DWELL for 8 clk with `cw`=`ccw`=0; RUN with `ccw`=1 and `power` ramping from 0.
4. Stop:
   - Stimulus: `run`=0 at `power`=7.
   - Response: ramp to 0 in 28 clk; DWELL 8 clk; IDLE with all outputs 0.
5. Fault:
   - Stimulus: `fault`=1 for 1 clk in RUN at `power`=9.
   - Response: next edge `power`=0, `enable`=0, `fault_latched`=1, `state`=4.
   - Stimulus: then `fault_clr`=1 with `run` still 1.
   - Response: IDLE with no restart until `run` toggles 0→1.
6. Async reset:
   - Stimulus: assert `rst_n`=0 mid-STOP.
   - Response: all outputs 0 immediately without a clock edge; `cw`&`ccw` never both 1 across the entire run (check with an assertion).
